// File: rtl/accelerator_pkg.sv
// Shared definitions for the accelerator slice.
//   DATA_W / FRAC  : Q8.8 word format
//   ACC_W          : MAC accumulator width
//   KSIZE / PSIZE  : convolution kernel side, pooling window side
//   state_t        : sequencer state encoding
//   saturate       : clamp an accumulator value into a signed data word
//   relu_sat       : clamp negatives to zero, then saturate
package accelerator_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC   = 8;
    localparam int ACC_W  = 40;
    localparam int KSIZE  = 3;
    localparam int PSIZE  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        POOL  = 3'd2,
        DENSE = 3'd3,
        ACT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic signed [ACC_W-1:0]  SAT_HI   = 40'sd32767;
    localparam logic signed [ACC_W-1:0]  SAT_LO   = -40'sd32768;
    localparam logic signed [DATA_W-1:0] WORD_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] WORD_MIN = 16'sh8000;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] x);
        logic signed [DATA_W-1:0] r;
        if (x > SAT_HI) begin
            r = WORD_MAX;
        end else if (x < SAT_LO) begin
            r = WORD_MIN;
        end else begin
            r = x[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] x);
        logic signed [DATA_W-1:0] r;
        if (x[ACC_W-1]) begin
            r = '0;
        end else begin
            r = saturate(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/accelerator_mac_unit.sv
// Single-multiplier multiply-accumulate.
//   clk, rst : clock, async active-high reset
//   clear    : zero the accumulator
//   en       : accumulate a*b this cycle
//   load     : start a fresh sum with this product (ignore the old accumulator)
//   a, b     : signed Q8.8 operands
//   acc      : registered accumulator
//   result   : (accumulator including this cycle's product) >>> FRAC, saturated;
//              valid in the same cycle as the last product of a sum
module mac_unit
    import accelerator_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    product_ext;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;

    assign product     = a * b;
    assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

    always_comb begin
        base = acc;
        if (load) begin
            base = '0;
        end
    end

    assign sum     = base + product_ext;
    // arithmetic shift floors toward minus infinity
    assign shifted = sum >>> FRAC;
    assign result  = saturate(shifted);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/accelerator.sv
// Tiny CNN inference engine: 3x3 valid conv -> ReLU -> 2x2/2 max-pool ->
// dense to one output -> +bias -> ReLU -> saturate. Image, kernel and dense
// weights come from constant ROMs; one multiply per cycle through mac_unit.
//   clk       : clock
//   reset     : async active-high reset, aborts any inference
//   start     : one-cycle pulse, accepted in IDLE or DONE
//   done_out  : high while final_out holds a valid result
//   final_out : signed Q8.8 classification score
//
// state | meaning
// IDLE  | waiting for start
// CONV  | one kernel tap per cycle, conv word written on the ninth tap
// POOL  | one 2x2 maximum per cycle
// DENSE | one pooled value times weight per cycle
// ACT   | bias, ReLU and saturation applied; result lands on entry to DONE
// DONE  | result valid and held, start reruns
module accelerator #(
    parameter int DATA_W     = 16,
    parameter int IMG        = 8,
    parameter int DENSE_BIAS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     done_out,
    output logic signed [DATA_W-1:0] final_out
);
    import accelerator_pkg::*;

    localparam int CONV_N     = IMG - KSIZE + 1;
    localparam int POOL_N     = CONV_N / PSIZE;
    localparam int CONV_WORDS = CONV_N * CONV_N;
    localparam int POOL_WORDS = POOL_N * POOL_N;
    localparam int CW         = $clog2(CONV_WORDS);
    localparam int PW         = $clog2(POOL_WORDS);
    localparam int CNT_W      = 8;

    localparam logic signed [DATA_W-1:0] KERNEL_TAP = 16'sd16;
    localparam logic signed [DATA_W-1:0] DENSE_WT   = 16'sd32;
    localparam logic signed [DATA_W-1:0] BIAS_Q     = DATA_W'(DENSE_BIAS);

    state_t state, state_next;

    logic [CNT_W-1:0] k_r, k_c, out_r, out_c, p_r, p_c, d_idx;

    logic signed [DATA_W-1:0] conv_buf [CONV_WORDS];
    logic signed [DATA_W-1:0] pool_buf [POOL_WORDS];
    logic signed [DATA_W-1:0] dense_val;

    logic                     mac_en, mac_load, mac_clear, start_ok;
    logic signed [DATA_W-1:0] mac_a, mac_b, mac_result;
    logic signed [ACC_W-1:0]  mac_acc;

    logic last_tap, last_conv, last_pool, last_dense;
    logic [CW-1:0] conv_wr_idx;
    logic [PW-1:0] pool_wr_idx;
    logic signed [DATA_W-1:0] pix, pool_max;
    logic signed [ACC_W-1:0]  biased;
    int pool_base;

    assign last_tap   = (k_r == CNT_W'(KSIZE-1)) && (k_c == CNT_W'(KSIZE-1));
    assign last_conv  = (out_r == CNT_W'(CONV_N-1)) && (out_c == CNT_W'(CONV_N-1));
    assign last_pool  = (p_r == CNT_W'(POOL_N-1)) && (p_c == CNT_W'(POOL_N-1));
    assign last_dense = (d_idx == CNT_W'(POOL_WORDS-1));

    assign conv_wr_idx = CW'(int'(out_r) * CONV_N + int'(out_c));
    assign pool_wr_idx = PW'(int'(p_r) * POOL_N + int'(p_c));

    // image ROM: pixel(r,c) = (r+c) * 0.25 in Q8.8
    assign pix = DATA_W'((int'(out_r) + int'(k_r) + int'(out_c) + int'(k_c)) * 64);

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign mac_clear = start_ok;
    assign done_out  = (state == DONE);

    always_comb begin
        pool_base = int'(p_r) * PSIZE * CONV_N + int'(p_c) * PSIZE;
        pool_max  = conv_buf[CW'(pool_base)];
        for (int dr = 0; dr < PSIZE; dr++) begin
            for (int dc = 0; dc < PSIZE; dc++) begin
                if (conv_buf[CW'(pool_base + dr * CONV_N + dc)] > pool_max) begin
                    pool_max = conv_buf[CW'(pool_base + dr * CONV_N + dc)];
                end
            end
        end
    end

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state == CONV) begin
            mac_a = pix;
            mac_b = KERNEL_TAP;
        end else if (state == DENSE) begin
            mac_a = pool_buf[PW'(d_idx)];
            mac_b = DENSE_WT;
        end
    end

    assign biased = {{(ACC_W-DATA_W){dense_val[DATA_W-1]}}, dense_val}
                  + {{(ACC_W-DATA_W){BIAS_Q[DATA_W-1]}}, BIAS_Q};

    mac_unit u_mac (
        .clk    (clk),
        .rst    (reset),
        .clear  (mac_clear),
        .en     (mac_en),
        .load   (mac_load),
        .a      (mac_a),
        .b      (mac_b),
        .acc    (mac_acc),
        .result (mac_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mac_en     = 1'b0;
        mac_load   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                mac_en   = 1'b1;
                mac_load = (k_r == '0) && (k_c == '0);
                if (last_tap && last_conv) begin
                    state_next = POOL;
                end
            end
            POOL: begin
                if (last_pool) begin
                    state_next = DENSE;
                end
            end
            DENSE: begin
                mac_en   = 1'b1;
                mac_load = (d_idx == '0);
                if (last_dense) begin
                    state_next = ACT;
                end
            end
            ACT: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r       <= '0;
            k_c       <= '0;
            out_r     <= '0;
            out_c     <= '0;
            p_r       <= '0;
            p_c       <= '0;
            d_idx     <= '0;
            dense_val <= '0;
            final_out <= '0;
            conv_buf  <= '{default: '0};
            pool_buf  <= '{default: '0};
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        k_r   <= '0;
                        k_c   <= '0;
                        out_r <= '0;
                        out_c <= '0;
                        p_r   <= '0;
                        p_c   <= '0;
                        d_idx <= '0;
                    end
                end
                CONV: begin
                    if (k_c == CNT_W'(KSIZE-1)) begin
                        k_c <= '0;
                        if (k_r == CNT_W'(KSIZE-1)) begin
                            k_r <= '0;
                            conv_buf[conv_wr_idx] <= mac_result[DATA_W-1] ? '0 : mac_result;
                            if (out_c == CNT_W'(CONV_N-1)) begin
                                out_c <= '0;
                                out_r <= out_r + 1'b1;
                            end else begin
                                out_c <= out_c + 1'b1;
                            end
                        end else begin
                            k_r <= k_r + 1'b1;
                        end
                    end else begin
                        k_c <= k_c + 1'b1;
                    end
                end
                POOL: begin
                    pool_buf[pool_wr_idx] <= pool_max;
                    if (p_c == CNT_W'(POOL_N-1)) begin
                        p_c <= '0;
                        p_r <= p_r + 1'b1;
                    end else begin
                        p_c <= p_c + 1'b1;
                    end
                end
                DENSE: begin
                    d_idx <= d_idx + 1'b1;
                    if (last_dense) begin
                        dense_val <= mac_result;
                    end
                end
                ACT: begin
                    final_out <= relu_sat(biased);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator.sv
module tb_accelerator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic               done_out, done_neg, done_sat;
    logic signed [15:0] final_out, final_neg, final_sat;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc, done_cyc;
    int lat0, lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    accelerator dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done_out  (done_out),
        .final_out (final_out)
    );

    accelerator #(.DENSE_BIAS(-2000)) dut_neg (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done_out  (done_neg),
        .final_out (final_neg)
    );

    accelerator #(.DENSE_BIAS(32767)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done_out  (done_sat),
        .final_out (final_sat)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(output int latency);
        int n;
        n = 0;
        while (!done_out && n < 1000) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        check_val("done_rise", int'(done_out), 1);
        latency = done_cyc - start_cyc;
    endtask

    initial begin
        // reset and idle
        repeat (5) @(negedge clk);
        check_val("rst_done", int'(done_out), 0);
        check_val("rst_final", int'(final_out), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("idle_done", int'(done_out), 0);
        check_val("idle_final", int'(final_out), 0);

        // first inference, all three bias variants run in lockstep
        pulse_start();
        check_val("run1_busy", int'(done_out), 0);
        wait_done(lat0);
        check_val("lat_bound", int'(lat0 <= 1000), 1);
        check_val("run1_final", int'(final_out), 324);
        check_val("conv_0_0", int'(dut.conv_buf[0]), 72);
        check_val("conv_5_5", int'(dut.conv_buf[35]), 432);
        check_val("conv_1_2", int'(dut.conv_buf[8]), 180);
        check_val("pool_0_0", int'(dut.pool_buf[0]), 144);
        check_val("pool_2_2", int'(dut.pool_buf[8]), 432);
        check_val("neg_done", int'(done_neg), 1);
        check_val("neg_final", int'(final_neg), 0);
        check_val("sat_final", int'(final_sat), 32767);

        // result held in DONE
        repeat (20) @(negedge clk);
        check_val("hold_done", int'(done_out), 1);
        check_val("hold_final", int'(final_out), 324);

        // reset mid-inference aborts, then a clean rerun
        pulse_start();
        check_val("rerun_clears_done", int'(done_out), 0);
        check_val("rerun_holds_final", int'(final_out), 324);
        repeat (100) @(negedge clk);
        check_val("mid_busy", int'(done_out), 0);
        reset = 1'b1;
        #1;
        check_val("async_rst_final", int'(final_out), 0);
        check_val("async_rst_done", int'(done_out), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        check_val("post_rst_idle", int'(done_out), 0);
        check_val("post_rst_final", int'(final_out), 0);
        pulse_start();
        wait_done(lat);
        check_val("rst_rerun_lat", lat, lat0);
        check_val("rst_rerun_final", int'(final_out), 324);

        // start during CONV is ignored
        pulse_start();
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ignored_busy", int'(done_out), 0);
        wait_done(lat);
        check_val("ignored_lat", lat, lat0);
        check_val("ignored_final", int'(final_out), 324);

        // rerun from DONE
        pulse_start();
        check_val("done_drop", int'(done_out), 0);
        wait_done(lat);
        check_val("rerun_lat", lat, lat0);
        check_val("rerun_final", int'(final_out), 324);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
